// File: rtl/ddr_clock_gen_chan.sv
// One output clock channel: phase offset, pattern lookup, registered bit pair, p/n ddr_out legs.
// Latency: 1 cycle from ph to ddr_out inputs plus ddr_out latency; no backpressure.
module ddr_clock_gen_chan #(
    parameter int RATIO     = 10,
    parameter int HIGH_BITS = RATIO / 2,
    parameter int PW        = $clog2(RATIO)
) (
    input  logic          clk_x5,
    input  logic          rst_n_x5,
    input  logic [PW-1:0] ph,
    input  logic          emit,
    input  logic          step_vld,
    input  logic          step_dir,
    output logic          qp,
    output logic          qn
);

    localparam int            SW      = PW + 1;
    localparam logic [SW-1:0] RATIO_S = SW'(RATIO);
    localparam logic [SW-1:0] HIGH_S  = SW'(HIGH_BITS);
    localparam logic [PW-1:0] OFF_MAX = PW'(RATIO - 1);

    logic [PW-1:0] off;
    logic [SW-1:0] sum_rise;
    logic [SW-1:0] sum_fall;
    logic [SW-1:0] idx_rise;
    logic [SW-1:0] idx_fall;
    logic          p_rise;
    logic          p_fall;

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            off <= '0;
        end else if (step_vld) begin
            if (step_dir) begin
                off <= (off == OFF_MAX) ? '0 : off + PW'(1);
            end else begin
                off <= (off == '0) ? OFF_MAX : off - PW'(1);
            end
        end
    end

    // Sums never reach 2*RATIO, so one conditional subtract wraps them.
    always_comb begin
        sum_rise = {1'b0, ph} + {1'b0, off};
        sum_fall = sum_rise + SW'(1);
        idx_rise = (sum_rise >= RATIO_S) ? sum_rise - RATIO_S : sum_rise;
        idx_fall = (sum_fall >= RATIO_S) ? sum_fall - RATIO_S : sum_fall;
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            p_rise <= 1'b0;
            p_fall <= 1'b0;
        end else begin
            p_rise <= emit & (idx_rise < HIGH_S);
            p_fall <= emit & (idx_fall < HIGH_S);
        end
    end

    ddr_out u_ddr_p (
        .clk_x5   (clk_x5),
        .rst_n_x5 (rst_n_x5),
        .d_rise   (p_rise),
        .d_fall   (p_fall),
        .q        (qp)
    );

    ddr_out u_ddr_n (
        .clk_x5   (clk_x5),
        .rst_n_x5 (rst_n_x5),
        .d_rise   (~p_rise),
        .d_fall   (~p_fall),
        .q        (qn)
    );

endmodule

// File: rtl/ddr_out.sv
// Output DDR cell: both halves captured on the rising edge, rise bit driven while clk_x5 is high.
// Latency: 1 cycle from d_rise/d_fall to q; no backpressure.
module ddr_out (
    input  logic clk_x5,
    input  logic rst_n_x5,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_rise;
            fall_q <= d_fall;
        end
    end

    assign q = clk_x5 ? rise_q : fall_q;

endmodule

// File: rtl/ddr_clock_gen.sv
// Phase-locked pseudo-differential clock generator: shared phase counter, run/stop FSM, phase-step handshake.
// Latency: 1 cycle to ddr_out inputs, starts/stops on pattern boundaries; steps while phase_busy are dropped.
module ddr_clock_gen #(
    parameter int  RATIO         = 10,
    parameter int  HIGH_BITS     = RATIO / 2,
    parameter int  N_CHAN        = 1,
    parameter bit  START_RUNNING = 1'b1,
    parameter int  PW            = $clog2(RATIO),
    localparam int CW            = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic              clk_x5,
    input  logic              rst_n_x5,
    input  logic              en,
    output logic              active,
    input  logic              phase_step,
    input  logic              phase_dir,
    input  logic [CW-1:0]     phase_chan,
    output logic              phase_busy,
    output logic [N_CHAN-1:0] qp,
    output logic [N_CHAN-1:0] qn
);

    generate
        if (RATIO < 4 || (RATIO / 2) * 2 != RATIO || HIGH_BITS < 1 ||
            HIGH_BITS > RATIO - 1 || N_CHAN < 1) begin : g_bad_param
            $error("ddr_clock_gen: illegal RATIO, HIGH_BITS or N_CHAN");
        end
    endgenerate

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        STARTING = 2'd1,
        RUNNING  = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 2);

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] ph;
    logic          ph_first;
    logic          ph_last;
    logic          emit;

    logic          step_acc;
    logic          step_apply;
    logic          step_pend;
    logic          step_dir_q;
    logic [CW-1:0] step_chan_q;
    logic          apply_dir;
    logic [CW-1:0] apply_chan;

    assign ph_first = (ph == '0);
    assign ph_last  = (ph == PH_LAST);

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            ph <= '0;
        end else begin
            ph <= ph_last ? '0 : ph + PW'(2);
        end
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            state_q <= START_RUNNING ? RUNNING : STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED:  if (en) state_d = STARTING;
            STARTING: if (!en) state_d = STOPPED;
                      else if (ph_first) state_d = RUNNING;
            RUNNING:  if (!en) state_d = STOPPING;
            STOPPING: if (en) state_d = RUNNING;
                      else if (ph_last) state_d = STOPPED;
            default:  state_d = STOPPED;
        endcase
    end

    // The boundary pair in STARTING is the first emitted one, but only if en is still held.
    always_comb begin
        active = (state_q == RUNNING) || (state_q == STOPPING);
        emit   = active || ((state_q == STARTING) && en && ph_first);
    end

    // Offsets change on the edge into ph==0 so every period uses a single offset.
    assign step_acc   = phase_step & ~phase_busy;
    assign apply_dir  = step_acc ? phase_dir  : step_dir_q;
    assign apply_chan = step_acc ? phase_chan : step_chan_q;
    assign step_apply = (step_acc | step_pend) & ph_last;

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            step_pend   <= 1'b0;
            step_dir_q  <= 1'b0;
            step_chan_q <= '0;
            phase_busy  <= 1'b0;
        end else begin
            if (step_acc) begin
                step_dir_q  <= phase_dir;
                step_chan_q <= phase_chan;
            end
            if (step_apply) begin
                step_pend <= 1'b0;
            end else if (step_acc) begin
                step_pend <= 1'b1;
            end
            if (step_acc) begin
                phase_busy <= 1'b1;
            end else if (phase_busy && ph_first && !step_pend) begin
                phase_busy <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        ddr_clock_gen_chan #(
            .RATIO     (RATIO),
            .HIGH_BITS (HIGH_BITS),
            .PW        (PW)
        ) u_chan (
            .clk_x5   (clk_x5),
            .rst_n_x5 (rst_n_x5),
            .ph       (ph),
            .emit     (emit),
            .step_vld (step_apply && (apply_chan == CW'(c))),
            .step_dir (apply_dir),
            .qp       (qp[c]),
            .qn       (qn[c])
        );
    end

endmodule
